// File: rtl/ethernet_tx_frame_pkg.sv
// -----------------------------------------------------------------------------
// eth_tx_pkg
// Shared types and constants for the Ethernet transmit framer and for the
// byte-wide CRC-32 helper that the receive-side FCS checker also uses.
//   eth_tx_state_t : FSM state; the encoding is visible on o_fsm_state
//   PREAMBLE_BYTE / SFD_BYTE : wire symbols that open every frame
//   CRC_POLY / CRC_INIT      : reflected IEEE 802.3 CRC-32 constants
// -----------------------------------------------------------------------------
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6,
    ST_ABORT    = 3'd7
  } eth_tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          FCS_LEN       = 4;

  // Byte counter width (saturates at 2047) and per-state cycle timer width.
  localparam int          CNT_W         = 11;
  localparam int          TIMER_W       = 16;

endpackage

// File: rtl/ethernet_tx_frame_if.sv
// -----------------------------------------------------------------------------
// ethernet_tx_frame_if
// Upstream valid/ready byte stream feeding the framer. The signal names keep
// the framer's port-level view: i_* flow towards the framer, o_ready back.
//   i_valid : byte valid        i_data : byte
//   i_last  : final byte        o_ready: byte taken when i_valid & o_ready
// master = byte source, slave = framer.
// -----------------------------------------------------------------------------
interface ethernet_tx_frame_if;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_ready;

  modport master (output i_valid, output i_data, output i_last, input o_ready);
  modport slave  (input i_valid, input i_data, input i_last, output o_ready);
endinterface

// File: rtl/ethernet_tx_frame_crc32_d8.sv
// -----------------------------------------------------------------------------
// crc32_d8
// Combinational byte-wide CRC-32 next-state function (reflected 0xEDB88320,
// data bits taken LSB first, as they go onto the wire).
//   i_crc  [31:0] : current CRC register
//   i_byte [7:0]  : byte being appended
//   o_crc  [31:0] : CRC register after the byte
// No init or final XOR here; the caller owns both.
// -----------------------------------------------------------------------------
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  always_comb begin : p_crc
    logic [31:0] c;
    // NOTE: blocking assignments are deliberate here: each loop iteration
    // must see the value produced by the previous one within the same pass.
    c = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ i_byte[i]) c = (c >> 1) ^ CRC_POLY;
      else                  c = c >> 1;
    end
    o_crc = c;
  end

endmodule

// File: rtl/ethernet_tx_frame.sv
// -----------------------------------------------------------------------------
// ethernet_tx_frame
// Transmit Ethernet framer: takes frame bytes (DA..payload, no FCS) from an
// upstream stream and drives GMII with preamble, SFD, data, zero pad up to
// pMIN_FRAME, CRC-32 FCS (LSB first) and pIFG idle cycles.
//   i_tx_clk / i_rst_n      : GMII TX clock, async active-low reset
//   up (slave)              : upstream byte stream (valid/data/last/ready)
//   o_tx_en/o_tx_er/o_tx_d  : registered GMII outputs
//   o_fsm_state             : current state (what is on the wire this cycle)
//   o_fsm_state_changed     : high on the first cycle of a new state
// An upstream gap mid-frame (underrun) emits one error symbol and abandons
// the frame.
// -----------------------------------------------------------------------------
module ethernet_tx_frame
  import eth_tx_pkg::*;
#(
  parameter int pMIN_FRAME = 60,
  parameter int pIFG       = 12
) (
  input  logic                i_tx_clk,
  input  logic                i_rst_n,
  ethernet_tx_frame_if.slave  up,
  output logic                o_tx_en,
  output logic                o_tx_er,
  output logic [7:0]          o_tx_d,
  output logic [2:0]          o_fsm_state,
  output logic                o_fsm_state_changed
);

  localparam logic [CNT_W-1:0]   MIN_CNT  = CNT_W'(pMIN_FRAME);
  localparam logic [TIMER_W-1:0] PRE_LAST = TIMER_W'(PREAMBLE_LEN - 1);
  localparam logic [TIMER_W-1:0] FCS_LAST = TIMER_W'(FCS_LEN - 1);
  localparam logic [TIMER_W-1:0] IFG_LAST = TIMER_W'(pIFG - 1);

  eth_tx_state_t        r_state, w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [CNT_W-1:0]     r_count;
  logic [31:0]          r_crc, w_crc_nxt;
  logic                 r_last_q;
  logic                 r_tx_en, r_tx_er, r_state_changed;
  logic [7:0]           r_tx_d;
  logic                 w_tx_en_nxt, w_tx_er_nxt;
  logic [7:0]           w_tx_d_nxt, w_crc_byte;
  logic                 w_ready, w_accept, w_start;

  // Ready is a decode of the current state so the byte taken this cycle is
  // on the wire next cycle; last_q blocks bytes beyond the end of the frame.
  assign w_ready    = (r_state == ST_SFD) || ((r_state == ST_DATA) && !r_last_q);
  assign w_accept   = w_ready && up.i_valid;
  assign up.o_ready = w_ready;

  // Pad cycles append 0x00 to the CRC; accepted bytes append themselves.
  assign w_crc_byte = w_accept ? up.i_data : 8'h00;

  crc32_d8 u_crc (.i_crc(r_crc), .i_byte(w_crc_byte), .o_crc(w_crc_nxt));

  assign w_start = (w_state_nxt == ST_PREAMBLE) && (r_state != ST_PREAMBLE);

  // State register plus registered wire outputs, loaded from the next state
  // so the outputs always describe the state now held in r_state.
  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_state_changed <= 1'b0;
      r_tx_en         <= 1'b0;
      r_tx_er         <= 1'b0;
      r_tx_d          <= 8'h00;
    end else begin
      r_state         <= w_state_nxt;
      r_timer         <= (w_state_nxt != r_state) ? '0 : r_timer + 1'b1;
      r_state_changed <= (w_state_nxt != r_state);
      r_tx_en         <= w_tx_en_nxt;
      r_tx_er         <= w_tx_er_nxt;
      r_tx_d          <= w_tx_d_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven,
    // so no latch is inferred for states that simply hold.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (up.i_valid) w_state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: if (r_timer == PRE_LAST) w_state_nxt = ST_SFD;
      ST_SFD:      w_state_nxt = up.i_valid ? ST_DATA : ST_ABORT;
      ST_DATA: begin
        if (!r_last_q)                w_state_nxt = up.i_valid ? ST_DATA : ST_ABORT;
        else if (r_count < MIN_CNT)   w_state_nxt = ST_PAD;
        else                          w_state_nxt = ST_FCS;
      end
      ST_PAD:      if (r_count >= MIN_CNT) w_state_nxt = ST_FCS;
      ST_FCS:      if (r_timer == FCS_LAST) w_state_nxt = ST_IFG;
      ST_IFG:      if (r_timer == IFG_LAST) w_state_nxt = ST_IDLE;
      ST_ABORT:    w_state_nxt = ST_IFG;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Wire contents for the state being entered.
  always_comb begin
    w_tx_en_nxt = 1'b0;
    w_tx_er_nxt = 1'b0;
    w_tx_d_nxt  = 8'h00;
    case (w_state_nxt)
      ST_PREAMBLE: begin w_tx_en_nxt = 1'b1; w_tx_d_nxt = PREAMBLE_BYTE; end
      ST_SFD:      begin w_tx_en_nxt = 1'b1; w_tx_d_nxt = SFD_BYTE;      end
      ST_DATA:     begin w_tx_en_nxt = 1'b1; w_tx_d_nxt = up.i_data;     end
      ST_PAD:      w_tx_en_nxt = 1'b1;
      ST_FCS:      begin w_tx_en_nxt = 1'b1; w_tx_d_nxt = ~r_crc[7:0];   end
      ST_ABORT:    begin w_tx_en_nxt = 1'b1; w_tx_er_nxt = 1'b1;         end
      default:     ;
    endcase
  end

  // Byte counter, CRC and last flag. During FCS the CRC register is shifted
  // down a byte per cycle so bit 7:0 always holds the next FCS byte.
  always_ff @(posedge i_tx_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_crc    <= CRC_INIT;
      r_last_q <= 1'b0;
    end else if (w_start) begin
      r_count  <= '0;
      r_crc    <= CRC_INIT;
      r_last_q <= 1'b0;
    end else if (w_accept) begin
      r_crc    <= w_crc_nxt;
      r_count  <= (r_count == '1) ? r_count : r_count + 1'b1;
      r_last_q <= up.i_last;
    end else if (w_state_nxt == ST_PAD) begin
      r_crc    <= w_crc_nxt;
      r_count  <= (r_count == '1) ? r_count : r_count + 1'b1;
    end else if (w_state_nxt == ST_FCS) begin
      r_crc    <= {8'hFF, r_crc[31:8]};
    end
  end

  assign o_tx_en             = r_tx_en;
  assign o_tx_er             = r_tx_er;
  assign o_tx_d              = r_tx_d;
  assign o_fsm_state         = r_state;
  assign o_fsm_state_changed = r_state_changed;

endmodule

// File: tb/tb_ethernet_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_ethernet_tx_frame
// Bench for ethernet_tx_frame. Two instances: default parameters and one with
// pMIN_FRAME=9 for the CRC check value. Wire activity of the selected instance
// is sampled on the falling edge and compared against a frame model built
// from preamble/SFD/pad rules and a table-driven CRC-32.
// -----------------------------------------------------------------------------
module tb_ethernet_tx_frame;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [8:0] word_q_t[$];
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic [2:0] st;
    logic       chg;
    logic       rdy;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v_valid = 1'b0;
  logic       v_last = 1'b0;
  logic [7:0] v_data = 8'h00;
  logic       sel9 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ethernet_tx_frame_if bus ();
  ethernet_tx_frame_if bus9 ();

  assign bus.i_valid  = v_valid & ~sel9;
  assign bus.i_data   = v_data;
  assign bus.i_last   = v_last;
  assign bus9.i_valid = v_valid & sel9;
  assign bus9.i_data  = v_data;
  assign bus9.i_last  = v_last;

  logic       en0, er0, chg0, en9, er9, chg9;
  logic [7:0] d0, d9;
  logic [2:0] st0, st9;

  ethernet_tx_frame dut (
    .i_tx_clk(clk), .i_rst_n(rst_n), .up(bus),
    .o_tx_en(en0), .o_tx_er(er0), .o_tx_d(d0),
    .o_fsm_state(st0), .o_fsm_state_changed(chg0)
  );

  ethernet_tx_frame #(.pMIN_FRAME(9)) dut9 (
    .i_tx_clk(clk), .i_rst_n(rst_n), .up(bus9),
    .o_tx_en(en9), .o_tx_er(er9), .o_tx_d(d9),
    .o_fsm_state(st9), .o_fsm_state_changed(chg9)
  );

  logic       w_en, w_er, w_chg, w_rdy;
  logic [7:0] w_d;
  logic [2:0] w_st;
  assign w_en  = sel9 ? en9 : en0;
  assign w_er  = sel9 ? er9 : er0;
  assign w_d   = sel9 ? d9 : d0;
  assign w_st  = sel9 ? st9 : st0;
  assign w_chg = sel9 ? chg9 : chg0;
  assign w_rdy = sel9 ? bus9.o_ready : bus.o_ready;

  // ---------------- monitor ----------------
  samp_t      cap[$];
  bit         cap_on = 1'b0;
  int         mon_bad_chg = 0;
  int         mon_bad_rdy = 0;
  logic [2:0] prev_st = 3'd0;
  bit         prev_ok = 1'b0;
  bit         prev_sel = 1'b0;

  always @(negedge clk) begin
    if (cap_on) cap.push_back({w_en, w_er, w_d, w_st, w_chg, w_rdy});
    if (rst_n && prev_ok && (prev_sel == sel9) && (w_chg !== (w_st != prev_st)))
      mon_bad_chg <= mon_bad_chg + 1;
    // Ready may only be offered in SFD (2) or DATA (3).
    if (rst_n && w_rdy && !(w_st == 3'd2 || w_st == 3'd3))
      mon_bad_rdy <= mon_bad_rdy + 1;
    prev_ok  <= rst_n;
    prev_st  <= w_st;
    prev_sel <= sel9;
  end

  // ---------------- reference model ----------------
  logic [31:0] crc_tab [256];

  task automatic build_crc_table();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  function automatic logic [31:0] fcs_of(byte_q_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic byte_q_t model_wire(byte_q_t data, int min_len);
    byte_q_t     w;
    byte_q_t     body;
    logic [31:0] f;
    body = data;
    while (body.size() < min_len) body.push_back(8'h00);
    f = fcs_of(body);
    for (int i = 0; i < 7; i++) w.push_back(8'h55);
    w.push_back(8'hD5);
    foreach (body[i]) w.push_back(body[i]);
    for (int k = 0; k < 4; k++) w.push_back(f[8*k +: 8]);
    return w;
  endfunction

  function automatic byte_q_t rand_bytes(int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic word_q_t to_stream(byte_q_t b);
    word_q_t s;
    foreach (b[i]) s.push_back({(i == b.size() - 1), b[i]});
    return s;
  endfunction

  function automatic int first_diff(byte_q_t a, byte_q_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_stream(input word_q_t s, input int drop_after, output bit to);
    int idx;
    int budget;
    bit acc;
    idx = 0;
    budget = 4000 + 2 * s.size();
    v_valid = 1'b1; v_data = s[0][7:0]; v_last = s[0][8];
    while (idx < s.size() && budget > 0) begin
      @(negedge clk);
      acc = w_rdy & v_valid;
      @(posedge clk); #1;
      budget--;
      if (acc) begin
        idx++;
        if (idx == drop_after) begin
          v_valid = 1'b0;
          idx = s.size();
        end else if (idx < s.size()) begin
          v_data = s[idx][7:0]; v_last = s[idx][8];
        end else begin
          v_valid = 1'b0;
        end
      end
    end
    v_valid = 1'b0; v_last = 1'b0;
    to = (idx < s.size());
  endtask

  task automatic wait_idle(output bit to);
    int budget;
    budget = 6000;
    to = 1'b1;
    while (budget > 0 && to) begin
      @(negedge clk);
      budget--;
      if (w_st == 3'd0 && !w_en) to = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_capture(input word_q_t s, input int drop_after, output bit to);
    bit t1, t2;
    cap.delete();
    cap_on = 1'b1;
    drive_stream(s, drop_after, t1);
    wait_idle(t2);
    cap_on = 1'b0;
    to = t1 | t2;
  endtask

  task automatic next_run(inout int pos, output byte_q_t run, output int er_cnt, output int start);
    run = {};
    er_cnt = 0;
    while (pos < cap.size() && !cap[pos].en) pos++;
    start = pos;
    while (pos < cap.size() && cap[pos].en) begin
      run.push_back(cap[pos].d);
      if (cap[pos].er) er_cnt++;
      pos++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({bus.o_ready, en0, er0, d0, st0, chg0} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_dut: got %h expected 0", {bus.o_ready, en0, er0, d0, st0, chg0});
    end
    n_vec++;
    if ({bus9.o_ready, en9, er9, d9, st9, chg9} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_dut9: got %h expected 0", {bus9.o_ready, en9, er9, d9, st9, chg9});
    end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({en0, st0, bus.o_ready} !== 5'd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected 0", {en0, st0, bus.o_ready});
    end
  endtask

  task automatic test_crc_check();
    byte_q_t d, run, exp;
    int pos, er_cnt, start, k;
    bit to;
    for (int i = 0; i < 9; i++) d.push_back(8'(49 + i));
    sel9 = 1'b1;
    @(negedge clk);
    run_capture(to_stream(d), -1, to);
    sel9 = 1'b0;
    n_vec++;
    if (to) begin n_err++; $display("FAIL crc_timeout: got timeout expected completion"); end
    pos = 0;
    next_run(pos, run, er_cnt, start);
    exp = model_wire(d, 9);
    k = first_diff(run, exp);
    n_vec++;
    if (k != -1) begin
      n_err++;
      $display("FAIL crc_frame: differs at byte %0d (got len %0d expected len %0d)", k, run.size(), exp.size());
    end
    n_vec++;
    if (run.size() != 21) begin n_err++; $display("FAIL crc_en_len: got %0d expected 21", run.size()); end
    n_vec++;
    if (run.size() == 21 && {run[17], run[18], run[19], run[20]} !== 32'h2639F4CB) begin
      n_err++;
      $display("FAIL crc_fcs: got %h%h%h%h expected 2639F4CB", run[17], run[18], run[19], run[20]);
    end else if (run.size() != 21) begin
      n_err++;
      $display("FAIL crc_fcs: got frame of %0d bytes expected 21", run.size());
    end
  endtask

  task automatic test_padding();
    byte_q_t d, run, exp;
    int pos, er_cnt, start, k;
    int seq[$];
    int exp_seq[8] = '{0, 1, 2, 3, 4, 5, 6, 0};
    bit to, seq_ok;
    d = rand_bytes(14);
    run_capture(to_stream(d), -1, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL pad_timeout: got timeout expected completion"); end
    pos = 0;
    next_run(pos, run, er_cnt, start);
    exp = model_wire(d, 60);
    k = first_diff(run, exp);
    n_vec++;
    if (k != -1) begin n_err++; $display("FAIL pad_frame: differs at byte %0d", k); end
    n_vec++;
    if (run.size() != 72) begin n_err++; $display("FAIL pad_en_len: got %0d expected 72", run.size()); end
    foreach (cap[i]) if (seq.size() == 0 || seq[$] != int'(cap[i].st)) seq.push_back(int'(cap[i].st));
    seq_ok = (seq.size() == 8);
    if (seq_ok) for (int i = 0; i < 8; i++) if (seq[i] != exp_seq[i]) seq_ok = 1'b0;
    n_vec++;
    if (!seq_ok) begin n_err++; $display("FAIL pad_states: got %0d distinct steps expected 0-1-2-3-4-5-6-0", seq.size()); end
  endtask

  task automatic test_underrun();
    byte_q_t d, run, exp;
    int pos, er_cnt, start, ifg, k;
    bit to;
    d = rand_bytes(10);
    run_capture(to_stream(d), 3, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL underrun_timeout: got timeout expected completion"); end
    for (int i = 0; i < 7; i++) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    for (int i = 0; i < 3; i++) exp.push_back(d[i]);
    exp.push_back(8'h00);
    pos = 0;
    next_run(pos, run, er_cnt, start);
    k = first_diff(run, exp);
    n_vec++;
    if (k != -1) begin n_err++; $display("FAIL underrun_wire: differs at byte %0d (len %0d expected 12)", k, run.size()); end
    n_vec++;
    if (er_cnt != 1 || !cap[pos-1].er || cap[pos-1].st != 3'd7) begin
      n_err++;
      $display("FAIL underrun_abort: got er_cnt %0d state %0d expected 1 and 7", er_cnt, cap[pos-1].st);
    end
    ifg = 0;
    while (pos < cap.size() && !cap[pos].en && cap[pos].st == 3'd6) begin ifg++; pos++; end
    n_vec++;
    if (ifg != 12 || pos >= cap.size() || cap[pos].st != 3'd0) begin
      n_err++;
      $display("FAIL underrun_ifg: got %0d gap cycles expected 12 then idle", ifg);
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t f1, f2, r1, r2;
    word_q_t s, s2;
    int pos, e1, e2, st1, st2, end1, rdy_hi;
    bit to;
    f1 = rand_bytes(64);
    f2 = rand_bytes(64);
    s = to_stream(f1);
    s2 = to_stream(f2);
    foreach (s2[i]) s.push_back(s2[i]);
    run_capture(s, -1, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL b2b_timeout: got timeout expected completion"); end
    pos = 0;
    next_run(pos, r1, e1, st1);
    end1 = pos;
    next_run(pos, r2, e2, st2);
    n_vec++;
    if (first_diff(r1, model_wire(f1, 60)) != -1) begin n_err++; $display("FAIL b2b_frame1: wire differs from model"); end
    n_vec++;
    if (first_diff(r2, model_wire(f2, 60)) != -1) begin n_err++; $display("FAIL b2b_frame2: wire differs from model"); end
    n_vec++;
    if (st2 - end1 != 13) begin n_err++; $display("FAIL b2b_gap: got %0d idle cycles expected 13", st2 - end1); end
    rdy_hi = 0;
    for (int i = end1 - 4; i < st2 + 7 && i < cap.size(); i++) if (i >= 0 && cap[i].rdy) rdy_hi++;
    n_vec++;
    if (rdy_hi != 0) begin n_err++; $display("FAIL b2b_ready: got %0d ready cycles expected 0", rdy_hi); end
  endtask

  task automatic test_random_frames();
    int lens[$];
    byte_q_t d, run;
    int pos, er_cnt, start, k, exp_len;
    bit to;
    lens = '{1, 59, 60, 61, 2100};
    for (int i = 0; i < 12; i++) lens.push_back($urandom_range(200, 1));
    foreach (lens[n]) begin
      repeat ($urandom_range(4, 0)) @(negedge clk);
      d = rand_bytes(lens[n]);
      run_capture(to_stream(d), -1, to);
      n_vec++;
      if (to) begin n_err++; $display("FAIL rand_timeout: len %0d got timeout expected completion", lens[n]); end
      pos = 0;
      next_run(pos, run, er_cnt, start);
      k = first_diff(run, model_wire(d, 60));
      n_vec++;
      if (k != -1) begin n_err++; $display("FAIL rand_frame: len %0d differs at byte %0d", lens[n], k); end
      exp_len = 8 + ((lens[n] > 60) ? lens[n] : 60) + 4;
      n_vec++;
      if (run.size() != exp_len || er_cnt != 0) begin
        n_err++;
        $display("FAIL rand_en_len: len %0d got %0d en cycles er %0d expected %0d er 0", lens[n], run.size(), er_cnt, exp_len);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    int en_cnt, budget, pos, er_cnt, start;
    byte_q_t d, run;
    bit to;
    en_cnt = 0;
    budget = 300;
    v_valid = 1'b1; v_last = 1'b0; v_data = 8'($urandom);
    while (en_cnt < 28 && budget > 0) begin
      @(posedge clk); #1 v_data = 8'($urandom);
      @(negedge clk);
      budget--;
      if (en0) en_cnt++;
    end
    n_vec++;
    if (en_cnt != 28 || st0 != 3'd3) begin
      n_err++;
      $display("FAIL rst_mid_reach: got %0d en cycles state %0d expected 28 and 3", en_cnt, st0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({en0, er0, d0} !== 10'd0) begin n_err++; $display("FAIL rst_mid_wire: got %h expected 0", {en0, er0, d0}); end
    n_vec++;
    if ({st0, chg0, bus.o_ready} !== 5'd0) begin
      n_err++;
      $display("FAIL rst_mid_state: got %h expected 0", {st0, chg0, bus.o_ready});
    end
    v_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d = rand_bytes(10);
    run_capture(to_stream(d), -1, to);
    n_vec++;
    if (to) begin n_err++; $display("FAIL rst_mid_timeout: got timeout expected completion"); end
    pos = 0;
    next_run(pos, run, er_cnt, start);
    n_vec++;
    if (first_diff(run, model_wire(d, 60)) != -1) begin
      n_err++;
      $display("FAIL rst_mid_next_frame: wire differs from model (len %0d)", run.size());
    end
  endtask

  task automatic test_monitor_rules();
    n_vec++;
    if (mon_bad_chg != 0) begin n_err++; $display("FAIL state_changed_pulse: got %0d bad cycles expected 0", mon_bad_chg); end
    n_vec++;
    if (mon_bad_rdy != 0) begin n_err++; $display("FAIL ready_decode: got %0d bad cycles expected 0", mon_bad_rdy); end
  endtask

  initial begin
    build_crc_table();
    test_reset();
    test_crc_check();
    test_padding();
    test_underrun();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_data();
    test_monitor_rules();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
